dc_stall_queue: RTL and testbench
=================================

# dc_stall_queue

Parking buffer for coherence requests the directory controller cannot service because the addressed line is in a transient directory state (S_D, MN_A, SN_A, NS_D). It sits beside the directory request pipeline, directly downstream of the stall-decision logic: every request flagged as stalled is written here. It is re-issued to the pipeline input through a registered replay port once the blocking transaction on that line retires. Requests to the same line stay in arrival order; requests to different lines may overtake each other.

## Interface
- QUEUE_DEPTH, 8: parked-request capacity, excluding the output register; ≥2.
- ADDR_WIDTH, 26: cache-line address width.
- MSG_TYPE_WIDTH, `DIRECTORY_MESSAGE_TYPE_WIDTH`: request type width (GETS, GETM, REPLACEMENT, ...).
- SOURCE_WIDTH, 4: requesting tile id width.

Ports:
- clk  in  1  sole clock, rising edge.
- reset  in  1  asynchronous, active-high; clears all state.
- enqueue_valid  in  1  stalled request to park.
- enqueue_address  in  ADDR_WIDTH.
- enqueue_type  in  MSG_TYPE_WIDTH.
- enqueue_source  in  SOURCE_WIDTH.
- enqueue_ready  out  1  = !queue_full.
- wakeup_valid  in  1  one-cycle pulse: a transaction on wakeup_address retired.
- wakeup_address  in  ADDR_WIDTH.
- replay_valid  out  1  output register holds a request.
- replay_address, replay_type, replay_source  out  widths as enqueue.
- replay_ready  in  1  pipeline accepts replay.
- queue_full  out  1  array holds QUEUE_DEPTH entries.
- queue_empty  out  1  array and output register both empty.
- pending_count  out  $clog2(QUEUE_DEPTH+2)  array entries + replay_valid.

## Operation
- Storage: age-ordered array of QUEUE_DEPTH slots, oldest at slot 0, compacted. Each slot holds {valid, blocked, address, type, source}.
- Enqueue (enqueue_valid && enqueue_ready): write to the first free slot after this cycle's removal compaction, with blocked=1. An enqueue with enqueue_ready=0 is a protocol error. The upstream logic holds the request and does not assert enqueue_valid.
- Wakeup: every valid slot with address == wakeup_address gets blocked=0. A request enqueued in the same cycle is not affected and stays blocked. The output register is not affected.
- Eligibility: slot i is eligible iff valid, !blocked, and no older valid slot has the same address (head-of-line per address).
- Load: when the output register is empty, or is being emptied this cycle by a handshake, the oldest eligible slot moves into the output register. The slot is removed and younger slots shift down by one. All remaining slots with the same address are set blocked=1. If a wakeup for that address arrives in the same cycle, the re-block wins.
- Replay handshake: replay_valid && replay_ready. The output register empties, or reloads in the same cycle. The replay outputs stay stable while replay_valid=1 and replay_ready=0.
- Contract: the directory pulses wakeup for the line after every replayed request retires, whether or not it stalled again. A replayed request that stalls again is re-enqueued at the tail and waits for the next wakeup.
- Enqueue, wakeup, load and handshake may all occur in one cycle. Apply them in this order: removal/shift, re-block, wakeup, then append the enqueue.

## Timing
- Reset values: replay_valid=0, replay_* = 0, queue_full=0, queue_empty=1, pending_count=0, enqueue_ready=1. All slots are invalid.
- Wakeup at edge N makes a slot eligible at N; replay_valid rises at edge N+1 if the output register was free.
- Back-to-back replays of different lines: one per cycle with replay_ready held at 1.
- Enqueue to earliest replay: enqueue at edge N, wakeup at edge M > N gives replay_valid at M+1. Wakeup in the same cycle as the enqueue has no effect on that entry.
- queue_full and pending_count are registered and reflect state after the edge. enqueue_ready does not account for a same-cycle removal.
- Reset asserted mid-operation clears everything immediately (asynchronous). The in-flight replay is dropped.

## Test plan
- Park, then wakeup: enqueue GETS to 0x100 from src 2; wakeup 0x100 two cycles later. Required: replay_valid rises the next cycle carrying {0x100, GETS, 2}; pending_count goes 1→1→0 after the handshake.
- Per-line order: enqueue GETM 0x40 src1, GETS 0x40 src3, then wakeup 0x40. Required: src1 replays first and src3 is re-blocked. src3 replays only one cycle after a second wakeup 0x40.
- Overtake: enqueue A=0x10, B=0x20; wakeup 0x20 only. Required: B replays while A stays parked; pending_count=1 after B is accepted.
- Backpressure stability: with replay_valid=1 hold replay_ready=0 for 5 cycles, and wake an older line during that time. Required: replay outputs stay unchanged. The woken line replays in the cycle after replay_ready rises.
- Full: 8 enqueues give queue_full=1 and enqueue_ready=0. One wakeup plus load gives queue_full=0 on the next edge; a simultaneous enqueue and load at full leaves count=8 with the new entry at the tail.
- Reset with 5 parked entries and replay_valid=1: all outputs return to their reset values at once; no replay after release.

Source files
------------

// File: rtl/dc_stall_queue.sv
// Parking buffer for stalled directory requests: holds them blocked until their line
// retires a transaction, then replays the oldest eligible one through a registered port.
`ifndef DIRECTORY_MESSAGE_TYPE_WIDTH
`define DIRECTORY_MESSAGE_TYPE_WIDTH 3
`endif

module dc_stall_queue #(
  parameter int QUEUE_DEPTH    = 8,
  parameter int ADDR_WIDTH     = 26,
  parameter int MSG_TYPE_WIDTH = `DIRECTORY_MESSAGE_TYPE_WIDTH,
  parameter int SOURCE_WIDTH   = 4
) (
  input  logic                                 clk,
  input  logic                                 reset,
  input  logic                                 enqueue_valid,
  input  logic [ADDR_WIDTH-1:0]                enqueue_address,
  input  logic [MSG_TYPE_WIDTH-1:0]            enqueue_type,
  input  logic [SOURCE_WIDTH-1:0]              enqueue_source,
  output logic                                 enqueue_ready,
  input  logic                                 wakeup_valid,
  input  logic [ADDR_WIDTH-1:0]                wakeup_address,
  output logic                                 replay_valid,
  output logic [ADDR_WIDTH-1:0]                replay_address,
  output logic [MSG_TYPE_WIDTH-1:0]            replay_type,
  output logic [SOURCE_WIDTH-1:0]              replay_source,
  input  logic                                 replay_ready,
  output logic                                 queue_full,
  output logic                                 queue_empty,
  output logic [$clog2(QUEUE_DEPTH+2)-1:0]     pending_count
);

  localparam int IDX_W = $clog2(QUEUE_DEPTH);
  localparam int CNT_W = $clog2(QUEUE_DEPTH+2);

  logic [QUEUE_DEPTH-1:0]    slot_vld, slot_blk, nx_vld, nx_blk, elig;
  logic [ADDR_WIDTH-1:0]     slot_addr [QUEUE_DEPTH];
  logic [MSG_TYPE_WIDTH-1:0] slot_type [QUEUE_DEPTH];
  logic [SOURCE_WIDTH-1:0]   slot_src  [QUEUE_DEPTH];
  logic [ADDR_WIDTH-1:0]     nx_addr   [QUEUE_DEPTH];
  logic [MSG_TYPE_WIDTH-1:0] nx_type   [QUEUE_DEPTH];
  logic [SOURCE_WIDTH-1:0]   nx_src    [QUEUE_DEPTH];

  logic                      vld_p1;
  logic [ADDR_WIDTH-1:0]     addr_p1;
  logic [MSG_TYPE_WIDTH-1:0] type_p1;
  logic [SOURCE_WIDTH-1:0]   src_p1;

  logic [CNT_W-1:0] arr_cnt, arr_cnt_nx, wr_idx, pend_cnt;
  logic             full_q, empty_q, vld_p1_nx;
  logic [IDX_W-1:0] sel;
  logic             found, load_en, handshake, enq;
  logic [ADDR_WIDTH-1:0] sel_addr;

  // Head-of-line per address: an unblocked slot still waits behind any older same-line slot.
  always_comb begin
    elig = '0;
    for (int i = 0; i < QUEUE_DEPTH; i++) begin
      elig[i] = slot_vld[i] && !slot_blk[i];
      for (int j = 0; j < i; j++)
        if (slot_vld[j] && (slot_addr[j] == slot_addr[i])) elig[i] = 1'b0;
    end
  end

  always_comb begin
    sel   = '0;
    found = 1'b0;
    for (int i = 0; i < QUEUE_DEPTH; i++)
      if (elig[i] && !found) begin
        sel   = IDX_W'(i);
        found = 1'b1;
      end
  end

  assign handshake = vld_p1 && replay_ready;
  assign load_en   = found && (!vld_p1 || replay_ready);
  assign sel_addr  = slot_addr[sel];
  assign enq       = enqueue_valid && !full_q;
  assign wr_idx    = arr_cnt - CNT_W'(load_en);

  // Next array: compact out the loaded slot, re-block its line, apply wakeup, append enqueue.
  always_comb begin
    for (int i = 0; i < QUEUE_DEPTH-1; i++) begin
      if (load_en && (IDX_W'(i) >= sel)) begin
        nx_vld[i]  = slot_vld[i+1];
        nx_blk[i]  = slot_blk[i+1];
        nx_addr[i] = slot_addr[i+1];
        nx_type[i] = slot_type[i+1];
        nx_src[i]  = slot_src[i+1];
      end else begin
        nx_vld[i]  = slot_vld[i];
        nx_blk[i]  = slot_blk[i];
        nx_addr[i] = slot_addr[i];
        nx_type[i] = slot_type[i];
        nx_src[i]  = slot_src[i];
      end
    end
    nx_vld[QUEUE_DEPTH-1]  = load_en ? 1'b0 : slot_vld[QUEUE_DEPTH-1];
    nx_blk[QUEUE_DEPTH-1]  = slot_blk[QUEUE_DEPTH-1];
    nx_addr[QUEUE_DEPTH-1] = slot_addr[QUEUE_DEPTH-1];
    nx_type[QUEUE_DEPTH-1] = slot_type[QUEUE_DEPTH-1];
    nx_src[QUEUE_DEPTH-1]  = slot_src[QUEUE_DEPTH-1];

    for (int i = 0; i < QUEUE_DEPTH; i++) begin
      if (nx_vld[i] && load_en && (nx_addr[i] == sel_addr))
        nx_blk[i] = 1'b1;
      else if (nx_vld[i] && wakeup_valid && (nx_addr[i] == wakeup_address))
        nx_blk[i] = 1'b0;
      if (enq && (CNT_W'(i) == wr_idx)) begin
        nx_vld[i]  = 1'b1;
        nx_blk[i]  = 1'b1;
        nx_addr[i] = enqueue_address;
        nx_type[i] = enqueue_type;
        nx_src[i]  = enqueue_source;
      end
    end
  end

  assign arr_cnt_nx = arr_cnt - CNT_W'(load_en) + CNT_W'(enq);
  assign vld_p1_nx  = load_en || (vld_p1 && !handshake);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      slot_vld <= '0;
      slot_blk <= '0;
      arr_cnt  <= '0;
      pend_cnt <= '0;
      full_q   <= 1'b0;
      empty_q  <= 1'b1;
      vld_p1   <= 1'b0;
      addr_p1  <= '0;
      type_p1  <= '0;
      src_p1   <= '0;
    end else begin
      slot_vld <= nx_vld;
      slot_blk <= nx_blk;
      arr_cnt  <= arr_cnt_nx;
      pend_cnt <= arr_cnt_nx + CNT_W'(vld_p1_nx);
      full_q   <= (arr_cnt_nx == CNT_W'(QUEUE_DEPTH));
      empty_q  <= (arr_cnt_nx == '0) && !vld_p1_nx;
      vld_p1   <= vld_p1_nx;
      // ---- output register stage (p1) ----
      if (load_en) begin
        addr_p1 <= sel_addr;
        type_p1 <= slot_type[sel];
        src_p1  <= slot_src[sel];
      end
    end
  end

  // Payload of invalid slots is don't-care, so slot data carries no reset.
  always_ff @(posedge clk) begin
    for (int i = 0; i < QUEUE_DEPTH; i++) begin
      slot_addr[i] <= nx_addr[i];
      slot_type[i] <= nx_type[i];
      slot_src[i]  <= nx_src[i];
    end
  end

  assign enqueue_ready  = !full_q;
  assign queue_full     = full_q;
  assign queue_empty    = empty_q;
  assign pending_count  = pend_cnt;
  assign replay_valid   = vld_p1;
  assign replay_address = addr_p1;
  assign replay_type    = type_p1;
  assign replay_source  = src_p1;

endmodule

// File: tb/tb_dc_stall_queue.sv
// Directed bench for dc_stall_queue: parking, wakeup, per-line ordering, overtaking,
// backpressure, full handling and asynchronous reset.
module tb_dc_stall_queue;

  localparam logic [2:0] GETS = 3'd0;
  localparam logic [2:0] GETM = 3'd1;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        enqueue_valid = 1'b0;
  logic [25:0] enqueue_address = '0;
  logic [2:0]  enqueue_type = '0;
  logic [3:0]  enqueue_source = '0;
  logic        enqueue_ready;
  logic        wakeup_valid = 1'b0;
  logic [25:0] wakeup_address = '0;
  logic        replay_valid;
  logic [25:0] replay_address;
  logic [2:0]  replay_type;
  logic [3:0]  replay_source;
  logic        replay_ready = 1'b0;
  logic        queue_full, queue_empty;
  logic [3:0]  pending_count;

  int checks = 0;
  int errors = 0;

  dc_stall_queue #(
    .QUEUE_DEPTH(8), .ADDR_WIDTH(26), .MSG_TYPE_WIDTH(3), .SOURCE_WIDTH(4)
  ) dut (
    .clk(clk), .reset(reset),
    .enqueue_valid(enqueue_valid), .enqueue_address(enqueue_address),
    .enqueue_type(enqueue_type), .enqueue_source(enqueue_source),
    .enqueue_ready(enqueue_ready),
    .wakeup_valid(wakeup_valid), .wakeup_address(wakeup_address),
    .replay_valid(replay_valid), .replay_address(replay_address),
    .replay_type(replay_type), .replay_source(replay_source),
    .replay_ready(replay_ready),
    .queue_full(queue_full), .queue_empty(queue_empty),
    .pending_count(pending_count)
  );

  always #5 clk = ~clk;

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic enq(input logic [25:0] a, input logic [2:0] t, input logic [3:0] s);
    enqueue_valid = 1'b1; enqueue_address = a; enqueue_type = t; enqueue_source = s;
    tick;
    enqueue_valid = 1'b0;
  endtask

  task automatic wake(input logic [25:0] a);
    wakeup_valid = 1'b1; wakeup_address = a;
    tick;
    wakeup_valid = 1'b0;
  endtask

  task automatic apply_reset;
    enqueue_valid = 1'b0; wakeup_valid = 1'b0; replay_ready = 1'b0;
    reset = 1'b1;
    tick;
    reset = 1'b0;
  endtask

  task automatic test_reset;
    tick;
    checks++; if (replay_valid !== 1'b0) begin errors++; $display("FAIL rst_valid: got %0b want 0", replay_valid); end
    checks++; if (replay_address !== 26'h0 || replay_type !== 3'd0 || replay_source !== 4'd0) begin
      errors++; $display("FAIL rst_payload: got %h/%0d/%0d want 0/0/0", replay_address, replay_type, replay_source); end
    checks++; if (queue_full !== 1'b0) begin errors++; $display("FAIL rst_full: got %0b want 0", queue_full); end
    checks++; if (queue_empty !== 1'b1) begin errors++; $display("FAIL rst_empty: got %0b want 1", queue_empty); end
    checks++; if (pending_count !== 4'd0) begin errors++; $display("FAIL rst_count: got %0d want 0", pending_count); end
    checks++; if (enqueue_ready !== 1'b1) begin errors++; $display("FAIL rst_ready: got %0b want 1", enqueue_ready); end
    reset = 1'b0;
  endtask

  task automatic test_park_wakeup;
    apply_reset;
    enq(26'h100, GETS, 4'd2);
    checks++; if (pending_count !== 4'd1) begin errors++; $display("FAIL park_cnt0: got %0d want 1", pending_count); end
    checks++; if (queue_empty !== 1'b0) begin errors++; $display("FAIL park_empty: got %0b want 0", queue_empty); end
    tick;
    wake(26'h100);
    checks++; if (replay_valid !== 1'b0) begin errors++; $display("FAIL park_early: got %0b want 0", replay_valid); end
    tick;
    checks++; if (replay_valid !== 1'b1 || replay_address !== 26'h100 || replay_type !== GETS || replay_source !== 4'd2) begin
      errors++; $display("FAIL park_replay: got v=%0b %h/%0d/%0d want 1 100/0/2", replay_valid, replay_address, replay_type, replay_source); end
    checks++; if (pending_count !== 4'd1) begin errors++; $display("FAIL park_cnt1: got %0d want 1", pending_count); end
    replay_ready = 1'b1; tick; replay_ready = 1'b0;
    checks++; if (replay_valid !== 1'b0 || pending_count !== 4'd0 || queue_empty !== 1'b1) begin
      errors++; $display("FAIL park_drain: got v=%0b cnt=%0d e=%0b want 0 0 1", replay_valid, pending_count, queue_empty); end
  endtask

  task automatic test_same_cycle_wake;
    apply_reset;
    enqueue_valid = 1'b1; enqueue_address = 26'h50; enqueue_type = GETM; enqueue_source = 4'd5;
    wakeup_valid = 1'b1; wakeup_address = 26'h50;
    tick;
    enqueue_valid = 1'b0; wakeup_valid = 1'b0;
    tick; tick;
    checks++; if (replay_valid !== 1'b0 || pending_count !== 4'd1) begin
      errors++; $display("FAIL samewake_blocked: got v=%0b cnt=%0d want 0 1", replay_valid, pending_count); end
    wake(26'h50);
    tick;
    checks++; if (replay_valid !== 1'b1 || replay_source !== 4'd5) begin
      errors++; $display("FAIL samewake_replay: got v=%0b src=%0d want 1 5", replay_valid, replay_source); end
  endtask

  task automatic test_line_order;
    apply_reset;
    enq(26'h40, GETM, 4'd1);
    enq(26'h40, GETS, 4'd3);
    wake(26'h40);
    tick;
    checks++; if (replay_valid !== 1'b1 || replay_source !== 4'd1 || replay_type !== GETM) begin
      errors++; $display("FAIL order_first: got v=%0b src=%0d t=%0d want 1 1 1", replay_valid, replay_source, replay_type); end
    checks++; if (pending_count !== 4'd2) begin errors++; $display("FAIL order_cnt2: got %0d want 2", pending_count); end
    replay_ready = 1'b1; tick; replay_ready = 1'b0;
    checks++; if (replay_valid !== 1'b0 || pending_count !== 4'd1) begin
      errors++; $display("FAIL order_reblock: got v=%0b cnt=%0d want 0 1", replay_valid, pending_count); end
    tick;
    checks++; if (replay_valid !== 1'b0) begin errors++; $display("FAIL order_still_blocked: got %0b want 0", replay_valid); end
    wake(26'h40);
    checks++; if (replay_valid !== 1'b0) begin errors++; $display("FAIL order_wake_edge: got %0b want 0", replay_valid); end
    tick;
    checks++; if (replay_valid !== 1'b1 || replay_source !== 4'd3 || replay_type !== GETS) begin
      errors++; $display("FAIL order_second: got v=%0b src=%0d t=%0d want 1 3 0", replay_valid, replay_source, replay_type); end
  endtask

  task automatic test_overtake;
    apply_reset;
    enq(26'h10, GETS, 4'd0);
    enq(26'h20, GETM, 4'd1);
    wake(26'h20);
    tick;
    checks++; if (replay_valid !== 1'b1 || replay_address !== 26'h20 || replay_source !== 4'd1) begin
      errors++; $display("FAIL overtake_b: got v=%0b a=%h src=%0d want 1 20 1", replay_valid, replay_address, replay_source); end
    replay_ready = 1'b1; tick; replay_ready = 1'b0;
    checks++; if (replay_valid !== 1'b0 || pending_count !== 4'd1 || queue_empty !== 1'b0) begin
      errors++; $display("FAIL overtake_a_parked: got v=%0b cnt=%0d e=%0b want 0 1 0", replay_valid, pending_count, queue_empty); end
  endtask

  task automatic test_backpressure;
    apply_reset;
    enq(26'h10, GETS, 4'd1);
    enq(26'h20, GETM, 4'd2);
    wake(26'h20);
    tick;
    for (int i = 0; i < 5; i++) begin
      if (i == 0) begin wakeup_valid = 1'b1; wakeup_address = 26'h10; end
      tick;
      wakeup_valid = 1'b0;
      checks++; if (replay_valid !== 1'b1 || replay_address !== 26'h20 || replay_type !== GETM || replay_source !== 4'd2) begin
        errors++; $display("FAIL bp_hold%0d: got v=%0b %h/%0d/%0d want 1 20/1/2", i, replay_valid, replay_address, replay_type, replay_source); end
    end
    replay_ready = 1'b1;
    tick;
    checks++; if (replay_valid !== 1'b1 || replay_address !== 26'h10 || replay_source !== 4'd1) begin
      errors++; $display("FAIL bp_woken: got v=%0b a=%h src=%0d want 1 10 1", replay_valid, replay_address, replay_source); end
    tick;
    replay_ready = 1'b0;
    checks++; if (replay_valid !== 1'b0 || pending_count !== 4'd0) begin
      errors++; $display("FAIL bp_drain: got v=%0b cnt=%0d want 0 0", replay_valid, pending_count); end
  endtask

  task automatic test_back_to_back;
    apply_reset;
    enq(26'h11, GETS, 4'd1);
    enq(26'h22, GETS, 4'd2);
    enq(26'h33, GETS, 4'd3);
    wake(26'h11);
    wake(26'h22);
    wake(26'h33);
    checks++; if (replay_valid !== 1'b1 || replay_address !== 26'h11) begin
      errors++; $display("FAIL b2b_0: got v=%0b a=%h want 1 11", replay_valid, replay_address); end
    replay_ready = 1'b1;
    tick;
    checks++; if (replay_valid !== 1'b1 || replay_address !== 26'h22) begin
      errors++; $display("FAIL b2b_1: got v=%0b a=%h want 1 22", replay_valid, replay_address); end
    tick;
    checks++; if (replay_valid !== 1'b1 || replay_address !== 26'h33) begin
      errors++; $display("FAIL b2b_2: got v=%0b a=%h want 1 33", replay_valid, replay_address); end
    tick;
    replay_ready = 1'b0;
    checks++; if (replay_valid !== 1'b0 || queue_empty !== 1'b1) begin
      errors++; $display("FAIL b2b_end: got v=%0b e=%0b want 0 1", replay_valid, queue_empty); end
  endtask

  task automatic test_full;
    apply_reset;
    for (int i = 0; i < 8; i++) enq(26'h200 + 26'(i), GETS, 4'(i));
    checks++; if (queue_full !== 1'b1 || enqueue_ready !== 1'b0 || pending_count !== 4'd8) begin
      errors++; $display("FAIL full_set: got f=%0b r=%0b cnt=%0d want 1 0 8", queue_full, enqueue_ready, pending_count); end
    wake(26'h200);
    checks++; if (queue_full !== 1'b1) begin errors++; $display("FAIL full_wake_edge: got %0b want 1", queue_full); end
    tick;
    checks++; if (queue_full !== 1'b0 || enqueue_ready !== 1'b1 || replay_address !== 26'h200 || pending_count !== 4'd8) begin
      errors++; $display("FAIL full_clear: got f=%0b r=%0b a=%h cnt=%0d want 0 1 200 8", queue_full, enqueue_ready, replay_address, pending_count); end
    wake(26'h201);
    replay_ready = 1'b1;
    enqueue_valid = 1'b1; enqueue_address = 26'h300; enqueue_type = GETM; enqueue_source = 4'd8;
    tick;
    replay_ready = 1'b0; enqueue_valid = 1'b0;
    checks++; if (pending_count !== 4'd8 || replay_address !== 26'h201 || replay_valid !== 1'b1) begin
      errors++; $display("FAIL full_swap: got cnt=%0d a=%h v=%0b want 8 201 1", pending_count, replay_address, replay_valid); end
    wake(26'h300);
    wake(26'h207);
    replay_ready = 1'b1;
    tick;
    checks++; if (replay_address !== 26'h207) begin errors++; $display("FAIL full_age: got %h want 207", replay_address); end
    tick;
    replay_ready = 1'b0;
    checks++; if (replay_valid !== 1'b1 || replay_address !== 26'h300 || replay_source !== 4'd8 || replay_type !== GETM) begin
      errors++; $display("FAIL full_tail: got v=%0b %h/%0d/%0d want 1 300/1/8", replay_valid, replay_address, replay_type, replay_source); end
  endtask

  task automatic test_reset_midop;
    apply_reset;
    for (int i = 0; i < 6; i++) enq(26'h400 + 26'(i), GETS, 4'(i));
    wake(26'h400);
    tick;
    checks++; if (replay_valid !== 1'b1 || pending_count !== 4'd6) begin
      errors++; $display("FAIL rmid_pre: got v=%0b cnt=%0d want 1 6", replay_valid, pending_count); end
    #2 reset = 1'b1;
    #1;
    checks++; if (replay_valid !== 1'b0 || replay_address !== 26'h0 || pending_count !== 4'd0) begin
      errors++; $display("FAIL rmid_async: got v=%0b a=%h cnt=%0d want 0 0 0", replay_valid, replay_address, pending_count); end
    checks++; if (queue_empty !== 1'b1 || queue_full !== 1'b0 || enqueue_ready !== 1'b1) begin
      errors++; $display("FAIL rmid_flags: got e=%0b f=%0b r=%0b want 1 0 1", queue_empty, queue_full, enqueue_ready); end
    tick;
    reset = 1'b0;
    wake(26'h401);
    replay_ready = 1'b1;
    tick; tick;
    replay_ready = 1'b0;
    checks++; if (replay_valid !== 1'b0 || pending_count !== 4'd0) begin
      errors++; $display("FAIL rmid_after: got v=%0b cnt=%0d want 0 0", replay_valid, pending_count); end
  endtask

  initial begin
    test_reset;
    test_park_wakeup;
    test_same_cycle_wake;
    test_line_order;
    test_overtake;
    test_backpressure;
    test_back_to_back;
    test_full;
    test_reset_midop;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
